// File: rtl/pe_cluster.sv
// pe_cluster: sixteen-lane int8 multiply-accumulate cluster.
// One IFM word (four packed signed int8 activations) is broadcast to all lanes;
// each lane holds its own packed weight word, a 32-bit wrapping accumulator and
// a registered 8-bit requantized result with a one-cycle valid pulse.
// Build option: define PE_RELU_EN to fuse ReLU into requantization (OFM unsigned
// 0..255); leave it undefined for signed saturation to -128..127.
module pe_cluster (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Weigh_0,
    input  logic [31:0] Weigh_1,
    input  logic [31:0] Weigh_2,
    input  logic [31:0] Weigh_3,
    input  logic [31:0] Weigh_4,
    input  logic [31:0] Weigh_5,
    input  logic [31:0] Weigh_6,
    input  logic [31:0] Weigh_7,
    input  logic [31:0] Weigh_8,
    input  logic [31:0] Weigh_9,
    input  logic [31:0] Weigh_10,
    input  logic [31:0] Weigh_11,
    input  logic [31:0] Weigh_12,
    input  logic [31:0] Weigh_13,
    input  logic [31:0] Weigh_14,
    input  logic [31:0] Weigh_15,
    input  logic [31:0] IFM,
    input  logic [15:0] PE_en,
    input  logic [15:0] PE_finish,
    output logic [7:0]  OFM_0,
    output logic [7:0]  OFM_1,
    output logic [7:0]  OFM_2,
    output logic [7:0]  OFM_3,
    output logic [7:0]  OFM_4,
    output logic [7:0]  OFM_5,
    output logic [7:0]  OFM_6,
    output logic [7:0]  OFM_7,
    output logic [7:0]  OFM_8,
    output logic [7:0]  OFM_9,
    output logic [7:0]  OFM_10,
    output logic [7:0]  OFM_11,
    output logic [7:0]  OFM_12,
    output logic [7:0]  OFM_13,
    output logic [7:0]  OFM_14,
    output logic [7:0]  OFM_15,
    output logic [15:0] valid
);

    logic        [31:0] weigh [16];
    logic signed [31:0] sum   [16];
    logic signed [31:0] acc_q [16];
    logic signed [31:0] acc_d [16];
    logic        [7:0]  ofm_q [16];
    logic        [7:0]  ofm_d [16];
    logic        [15:0] valid_q;
    logic        [15:0] valid_d;

    // Four signed int8 x int8 products (16-bit), sign-extended and summed.
    function automatic logic signed [31:0] dot4(input logic [31:0] w, input logic [31:0] a);
        logic signed [15:0] p;
        logic signed [31:0] s;
        s = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            p = $signed(w[8*k +: 8]) * $signed(a[8*k +: 8]);
            s = s + 32'(p);
        end
        return s;
    endfunction

    // Map the 32-bit window sum onto the 8-bit OFM range.
    function automatic logic [7:0] requant(input logic signed [31:0] s);
`ifdef PE_RELU_EN
        if (s < 0)
            return 8'h00;
        else if (s > 32'sd255)
            return 8'hFF;
        else
            return s[7:0];
`else
        if (s < -32'sd128)
            return 8'h80;
        else if (s > 32'sd127)
            return 8'h7F;
        else
            return s[7:0];
`endif
    endfunction

    assign weigh[0]  = Weigh_0;
    assign weigh[1]  = Weigh_1;
    assign weigh[2]  = Weigh_2;
    assign weigh[3]  = Weigh_3;
    assign weigh[4]  = Weigh_4;
    assign weigh[5]  = Weigh_5;
    assign weigh[6]  = Weigh_6;
    assign weigh[7]  = Weigh_7;
    assign weigh[8]  = Weigh_8;
    assign weigh[9]  = Weigh_9;
    assign weigh[10] = Weigh_10;
    assign weigh[11] = Weigh_11;
    assign weigh[12] = Weigh_12;
    assign weigh[13] = Weigh_13;
    assign weigh[14] = Weigh_14;
    assign weigh[15] = Weigh_15;

    // Per-lane window sum including this cycle's dot when enabled.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i] = acc_q[i] + (PE_en[i] ? dot4(weigh[i], IFM) : 32'sd0);
        end
    end

    // Per-lane next state: finish closes the window, enable accumulates, else hold.
    always_comb begin
        valid_d = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            acc_d[i] = acc_q[i];
            ofm_d[i] = ofm_q[i];
            if (PE_finish[i]) begin
                ofm_d[i]   = requant(sum[i]);
                valid_d[i] = 1'b1;
                acc_d[i]   = '0;
            end else if (PE_en[i]) begin
                acc_d[i] = sum[i];
            end
        end
    end

    // State registers; reset clears partial sums, results and valid at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                acc_q[i] <= '0;
                ofm_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                acc_q[i] <= acc_d[i];
                ofm_q[i] <= ofm_d[i];
            end
            valid_q <= valid_d;
        end
    end

    assign OFM_0  = ofm_q[0];
    assign OFM_1  = ofm_q[1];
    assign OFM_2  = ofm_q[2];
    assign OFM_3  = ofm_q[3];
    assign OFM_4  = ofm_q[4];
    assign OFM_5  = ofm_q[5];
    assign OFM_6  = ofm_q[6];
    assign OFM_7  = ofm_q[7];
    assign OFM_8  = ofm_q[8];
    assign OFM_9  = ofm_q[9];
    assign OFM_10 = ofm_q[10];
    assign OFM_11 = ofm_q[11];
    assign OFM_12 = ofm_q[12];
    assign OFM_13 = ofm_q[13];
    assign OFM_14 = ofm_q[14];
    assign OFM_15 = ofm_q[15];
    assign valid  = valid_q;

endmodule

// File: tb/tb_pe_cluster.sv
// Directed testbench for pe_cluster; expected values are hand-computed for
// either build (PE_RELU_EN defined or not).
module tb_pe_cluster;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wgt [16];
    logic [31:0] ifm;
    logic [15:0] pe_en;
    logic [15:0] pe_fin;
    logic [7:0]  ofm [16];
    logic [15:0] valid;

    int checks = 0;
    int errors = 0;

`ifdef PE_RELU_EN
    localparam logic [7:0] E2_OFM1 = 8'hAA, E2_OFM2 = 8'hFF, E2_OFM8 = 8'h00, E2_OFM15 = 8'h00;
    localparam logic [7:0] E3_OFM1 = 8'hFF, E3_OFM2 = 8'hFF, E3_OFM14 = 8'h00, E3_OFM15 = 8'h00;
    localparam logic [7:0] E4_OFM15 = 8'h00;
    localparam logic [7:0] E5_OFM8 = 8'h00, E5_OFM15 = 8'h00;
`else
    localparam logic [7:0] E2_OFM1 = 8'h7F, E2_OFM2 = 8'h7F, E2_OFM8 = 8'h80, E2_OFM15 = 8'hF6;
    localparam logic [7:0] E3_OFM1 = 8'h7F, E3_OFM2 = 8'h7F, E3_OFM14 = 8'h80, E3_OFM15 = 8'hE6;
    localparam logic [7:0] E4_OFM15 = 8'hFE;
    localparam logic [7:0] E5_OFM8 = 8'h88, E5_OFM15 = 8'hFF;
`endif

    always #5 clk = ~clk;

    pe_cluster dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Weigh_0  (wgt[0]),
        .Weigh_1  (wgt[1]),
        .Weigh_2  (wgt[2]),
        .Weigh_3  (wgt[3]),
        .Weigh_4  (wgt[4]),
        .Weigh_5  (wgt[5]),
        .Weigh_6  (wgt[6]),
        .Weigh_7  (wgt[7]),
        .Weigh_8  (wgt[8]),
        .Weigh_9  (wgt[9]),
        .Weigh_10 (wgt[10]),
        .Weigh_11 (wgt[11]),
        .Weigh_12 (wgt[12]),
        .Weigh_13 (wgt[13]),
        .Weigh_14 (wgt[14]),
        .Weigh_15 (wgt[15]),
        .IFM      (ifm),
        .PE_en    (pe_en),
        .PE_finish(pe_fin),
        .OFM_0    (ofm[0]),
        .OFM_1    (ofm[1]),
        .OFM_2    (ofm[2]),
        .OFM_3    (ofm[3]),
        .OFM_4    (ofm[4]),
        .OFM_5    (ofm[5]),
        .OFM_6    (ofm[6]),
        .OFM_7    (ofm[7]),
        .OFM_8    (ofm[8]),
        .OFM_9    (ofm[9]),
        .OFM_10   (ofm[10]),
        .OFM_11   (ofm[11]),
        .OFM_12   (ofm[12]),
        .OFM_13   (ofm[13]),
        .OFM_14   (ofm[14]),
        .OFM_15   (ofm[15]),
        .valid    (valid)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge where outputs are sampled
    // and the next inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        ifm     = 32'h01020304;
        pe_en   = 16'hFFFF;
        pe_fin  = 16'h0000;
        for (int i = 0; i < 16; i++) wgt[i] = 32'h11111111 * 32'(i);

        // Reset held with all lanes enabled: nothing accumulates, outputs clear.
        @(negedge clk);
        step();
        step();
        for (int i = 0; i < 16; i++) chk($sformatf("rst_ofm%0d", i), 16'(ofm[i]), 16'h0000);
        chk("rst_valid", valid, 16'h0000);

        // Single accumulate then finish, IFM byte sum 10 -> dot_i = 10 * w_i.
        reset_n = 1'b1;
        pe_en   = 16'hFFFF;
        step();
        chk("acc_valid_low", valid, 16'h0000);
        pe_en  = 16'h0000;
        pe_fin = 16'hFFFF;
        step();
        chk("fin1_valid", valid, 16'hFFFF);
        chk("fin1_ofm0", 16'(ofm[0]), 16'h0000);
        chk("fin1_ofm1", 16'(ofm[1]), 16'(E2_OFM1));
        chk("fin1_ofm2", 16'(ofm[2]), 16'(E2_OFM2));
        chk("fin1_ofm8", 16'(ofm[8]), 16'(E2_OFM8));
        chk("fin1_ofm15", 16'(ofm[15]), 16'(E2_OFM15));
        pe_fin = 16'h0000;
        step();
        chk("fin1_valid_drop", valid, 16'h0000);
        chk("fin1_ofm1_hold", 16'(ofm[1]), 16'(E2_OFM1));

        // Partial enables: odd lanes get 26*w, even lanes get 46*w.
        pe_en = 16'hAAAA;
        ifm   = 32'h05060708;
        step();
        pe_en = 16'h5555;
        ifm   = 32'h0A0B0C0D;
        step();
        pe_en  = 16'h0000;
        pe_fin = 16'hFFFF;
        step();
        chk("part_valid", valid, 16'hFFFF);
        chk("part_ofm0", 16'(ofm[0]), 16'h0000);
        chk("part_ofm1", 16'(ofm[1]), 16'(E3_OFM1));
        chk("part_ofm2", 16'(ofm[2]), 16'(E3_OFM2));
        chk("part_ofm14", 16'(ofm[14]), 16'(E3_OFM14));
        chk("part_ofm15", 16'(ofm[15]), 16'(E3_OFM15));

        // Enable and finish on the same edge; IFM=1 makes dot_i = byte0 of w_i.
        pe_fin = 16'h0000;
        ifm    = 32'h00000001;
        pe_en  = 16'h8008;
        step();
        pe_fin = 16'h8008;
        step();
        chk("samefin_valid", valid, 16'h8008);
        chk("samefin_ofm3", 16'(ofm[3]), 16'h0066);
        chk("samefin_ofm15", 16'(ofm[15]), 16'(E4_OFM15));
        chk("samefin_ofm1_hold", 16'(ofm[1]), 16'(E3_OFM1));
        pe_en = 16'h0000;
        step();
        chk("refin_valid", valid, 16'h8008);
        chk("refin_ofm3", 16'(ofm[3]), 16'h0000);
        chk("refin_ofm15", 16'(ofm[15]), 16'h0000);
        pe_fin = 16'h0000;
        step();
        chk("refin_valid_drop", valid, 16'h0000);

        // Async reset mid-window while lane 0 is pulsing valid.
        pe_en = 16'hFFFF;
        step();
        pe_fin = 16'h0001;
        step();
        chk("pre_rst_valid", valid, 16'h0001);
        chk("pre_rst_ofm1", 16'(ofm[1]), 16'(E3_OFM1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", valid, 16'h0000);
        chk("async_ofm1", 16'(ofm[1]), 16'h0000);
        chk("async_ofm2", 16'(ofm[2]), 16'h0000);
        pe_fin = 16'h0000;
        @(negedge clk);
        step();
        reset_n = 1'b1;
        pe_en   = 16'hFFFF;
        step();
        pe_en  = 16'h0000;
        pe_fin = 16'hFFFF;
        step();
        chk("post_valid", valid, 16'hFFFF);
        chk("post_ofm1", 16'(ofm[1]), 16'h0011);
        chk("post_ofm3", 16'(ofm[3]), 16'h0033);
        chk("post_ofm8", 16'(ofm[8]), 16'(E5_OFM8));
        chk("post_ofm15", 16'(ofm[15]), 16'(E5_OFM15));
        pe_fin = 16'h0000;
        step();
        chk("post_valid_drop", valid, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cluster.md
# pe_cluster

Sixteen-lane int8 multiply-accumulate cluster for the CNN datapath. One 32-bit IFM word, four packed int8 activations, is broadcast to all 16 processing elements (PEs). Each PE has its own 32-bit weight word and a 4-way dot-product accumulator. On a per-PE finish strobe, the PE requantizes its sum to an 8-bit OFM value and pulses a valid bit. It sits between the weight/IFM buffers and the OFM write-back logic.

## Interface
- No parameters. Lane count is 16, data byte width is 8, accumulator width is 32; all are fixed.
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- Weigh_0 … Weigh_15  in  32 each  per-PE weights; 4 signed int8 values, byte k = bits [8k+7:8k].
- IFM  in  32  broadcast activations; 4 signed int8 values, same byte packing.
- PE_en  in  16  bit i enables accumulation in PE i this cycle.
- PE_finish  in  16  bit i closes PE i's accumulation window.
- OFM_0 … OFM_15  out  8 each  registered requantized result of PE i.
- valid  out  16  bit i pulses high for one cycle when OFM_i is updated.

## Operation
- Per PE i: dot_i = Σ_{k=0..3} signed(Weigh_i[k]) × signed(IFM[k]). Products are 16-bit signed; the sum is sign-extended to 32 bits.
- Accumulator acc_i is 32-bit signed and wraps on overflow; no saturation inside the accumulator.
- At each rising edge, PE i takes exactly one of these actions:
  - PE_finish[i]=0, PE_en[i]=1: acc_i ← acc_i + dot_i.
  - PE_finish[i]=0, PE_en[i]=0: acc_i holds.
  - PE_finish[i]=1: let s = acc_i + (PE_en[i] ? dot_i : 0). Then OFM_i ← requant(s), valid[i] ← 1, acc_i ← 0.
- Any edge without PE_finish[i] sets valid[i] ← 0. OFM_i holds its last value between finishes.
- requant(s), with PE_RELU_EN defined: s<0 → 0x00; s>255 → 0xFF; otherwise s[7:0] (unsigned).
- requant(s), without PE_RELU_EN: clamp to [-128,127] and output as two's complement.
- Lanes are fully independent; any mix of enable and finish bits across lanes is legal.

## Timing
- Reset asserted (asynchronous): every acc_i = 0, OFM_i = 0x00, valid = 16'h0000 immediately, regardless of clk.
- Reset release is synchronous to the next rising edge; the first accumulation happens at the first edge with reset_n=1.
- Accumulation latency: PE_en sampled at edge n contributes to acc_i after edge n.
- Result latency: PE_finish sampled at edge n → OFM_i and valid[i] are valid after edge n and remain for one cycle (valid) or until the next finish (OFM).
- Back-to-back finishes on consecutive cycles are legal. Each finish emits the sum accumulated since the previous finish, which is 0 or the current-cycle dot only.
- Reset asserted mid-window discards partial sums; no valid pulse is produced.

## Configuration
- PE_RELU_EN defined: ReLU fused into requant; OFM is unsigned 0..255.
- PE_RELU_EN undefined: no ReLU; OFM is signed saturated -128..127.

## Test plan
- Reset check: hold reset_n=0 with PE_en=16'hFFFF → all OFM = 0x00, valid = 0; no accumulation.
- Single accumulate + finish (PE_RELU_EN): Weigh_i = 32'h11111111·i, IFM = 32'h01020304. PE_en=16'hFFFF for one edge, then PE_finish=16'hFFFF with PE_en=0 → OFM_1 = 0xAA (170), OFM_2 = 0xFF (340 saturated), OFM_0 = 0x00; valid = 16'hFFFF for exactly one cycle.
- Sign/ReLU: Weigh_8 = 32'h88888888 (−120 per byte) with the same IFM → s = −1200 → OFM_8 = 0x00 with PE_RELU_EN; 0x80 without.
- Partial enables: PE_en=16'hAAAA with IFM = 32'h05060708 for one edge, then 16'h5555 with IFM = 32'h0A0B0C0D for one edge, then finish all → odd lanes hold only the first dot, even lanes only the second; OFM_1 = 0xFF (26·17), OFM_0 = 0x00.
- Enable and finish on the same edge: PE_en[3] = PE_finish[3] = 1 after one prior enable edge → OFM_3 includes both dots; acc_3 = 0 afterwards, so a second finish yields 0x00.
- Async reset mid-window: assert reset_n=0 between clock edges after two enable edges → OFM/valid clear immediately; the next finish after release reports only post-reset sums.
